cpu_mc: RTL

// Parametrised multicycle successor to the single-cycle 8-bit core: same 16-bit ISA, but DW-bit datapath,
// PCW-bit byte PC and req/ack instruction and data memory ports that tolerate wait states.

---
 rtl/cpu_mc_if.sv | 27 ++
 rtl/cpu_mc.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mc_if.sv
// cpu_mc_if: instruction and data memory req/ack bus of the cpu_mc core.
// master = core side, slave = memory controller side.
interface cpu_mc_if #(
    parameter int unsigned DW  = 8,
    parameter int unsigned PCW = 8
);
    logic           I_REQ;
    logic [PCW-1:0] I_ADDR;
    logic           I_ACK;
    logic [15:0]    I_DATA;
    logic           D_REQ;
    logic           D_WE;
    logic [DW-1:0]  D_ADDR;
    logic [DW-1:0]  D_WDATA;
    logic           D_ACK;
    logic [DW-1:0]  D_RDATA;

    modport master (
        output I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA,
        input  I_ACK, I_DATA, D_ACK, D_RDATA
    );

    modport slave (
        input  I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA,
        output I_ACK, I_DATA, D_ACK, D_RDATA
    );
endinterface

// File: rtl/cpu_mc.sv
// cpu_mc: multicycle core for the 16-bit ISA with a DW-bit datapath, PCW-bit byte PC and
// req/ack instruction/data ports that tolerate wait states.
// Optional feature: define ILLEGAL_TRAP_EN to add the sticky ILLEGAL output and trap
// undefined opcodes into HALT; without it undefined opcodes retire as NOP.
module cpu_mc #(
    parameter int unsigned DW   = 8,
    parameter int unsigned PCW  = 8,
    parameter int unsigned NREG = 8
) (
    input  logic           CLK,
    input  logic           RESET_L,
    input  logic           EN_L,
    cpu_mc_if.master       bus,
    output logic [PCW-1:0] PC,
    output logic           HALTED,
`ifdef ILLEGAL_TRAP_EN
    output logic           RETIRE,
    output logic           ILLEGAL
`else
    output logic           RETIRE
`endif
);

    typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

    state_e         state_q;
    logic [15:0]    ir_q;
    logic [PCW-1:0] pc_q;
    logic           i_req_q;
    logic           d_req_q;
    logic           d_we_q;
    logic [DW-1:0]  d_addr_q;
    logic [DW-1:0]  d_wdata_q;
    logic           halted_q;
    logic           retire_q;
    logic           en_seen_q;
    logic [DW-1:0]  regs_q [NREG];
`ifdef ILLEGAL_TRAP_EN
    logic           illegal_q;
    logic           is_illegal;
`endif

    // Instruction fields
    logic [3:0] op;
    logic [2:0] rs, rt, rd, fn;
    logic [5:0] imm;
    assign op  = ir_q[15:12];
    assign rs  = ir_q[11:9];
    assign rt  = ir_q[8:6];
    assign rd  = ir_q[5:3];
    assign fn  = ir_q[2:0];
    assign imm = ir_q[5:0];

    // R0 always reads zero; writes are old-value-read since they land at the edge
    logic [DW-1:0] rs_val, rt_val;
    assign rs_val = (rs == 3'd0) ? '0 : regs_q[rs];
    assign rt_val = (rt == 3'd0) ? '0 : regs_q[rt];

    logic [DW-1:0]  imm_dw;
    logic [PCW-1:0] imm_pc, pc_inc, br_tgt;
    assign imm_dw = {{(DW-6){imm[5]}}, imm};
    assign imm_pc = {{(PCW-6){imm[5]}}, imm};
    assign pc_inc = pc_q + PCW'(2);
    assign br_tgt = pc_inc + (imm_pc << 1);

    logic          wr_en, br_taken, is_mem, is_halt;
    logic [2:0]    wr_idx;
    logic [DW-1:0] wr_val, alu_res;

    // ALU for register-register ops
    always_comb begin
        alu_res = '0;
        case (fn)
            3'b000:  alu_res = rs_val + rt_val;
            3'b001:  alu_res = rs_val - rt_val;
            3'b010:  alu_res = rs_val;
            3'b011:  alu_res = $signed(rs_val) >>> 1;
            3'b100:  alu_res = rs_val << 1;
            3'b101:  alu_res = rs_val & rt_val;
            3'b110:  alu_res = rs_val | rt_val;
            default: alu_res = rs_val ^ rt_val;
        endcase
    end

    // Instruction decode: register write, branch decision, memory/halt/illegal class
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = rt;
        wr_val   = '0;
        br_taken = 1'b0;
        is_mem   = 1'b0;
        is_halt  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        is_illegal = 1'b0;
`endif
        case (op)
            4'b0000: is_halt = (fn == 3'b001);
            4'b1111: begin
                wr_en  = 1'b1;
                wr_idx = rd;
                wr_val = alu_res;
            end
            4'b0010, 4'b0100: is_mem = 1'b1;
            4'b0101: begin wr_en = 1'b1; wr_val = rs_val + imm_dw; end
            4'b0110: begin wr_en = 1'b1; wr_val = rs_val & imm_dw; end
            4'b0111: begin wr_en = 1'b1; wr_val = rs_val | imm_dw; end
            4'b1000: br_taken = (rs_val == rt_val);
            4'b1001: br_taken = (rs_val != rt_val);
            4'b1010: br_taken = ~rs_val[DW-1];
            4'b1011: br_taken = rs_val[DW-1];
`ifdef ILLEGAL_TRAP_EN
            4'b0001, 4'b0011, 4'b1100, 4'b1101, 4'b1110: is_illegal = 1'b1;
`endif
            default: ;
        endcase
    end

    // Control FSM, register file and registered bus/status outputs
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q   <= StFetch;
            ir_q      <= '0;
            pc_q      <= '0;
            i_req_q   <= 1'b0;
            d_req_q   <= 1'b0;
            d_we_q    <= 1'b0;
            d_addr_q  <= '0;
            d_wdata_q <= '0;
            halted_q  <= 1'b0;
            retire_q  <= 1'b0;
            en_seen_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
        end else begin
            retire_q <= 1'b0;
            unique case (state_q)
                StFetch: begin
                    // Once raised, the request stays up until acked regardless of EN_L
                    if (!i_req_q) begin
                        if (!EN_L) i_req_q <= 1'b1;
                    end else if (bus.I_ACK) begin
                        i_req_q <= 1'b0;
                        ir_q    <= bus.I_DATA;
                        state_q <= StExec;
                    end
                end
                StExec: begin
`ifdef ILLEGAL_TRAP_EN
                    if (is_illegal) begin
                        illegal_q <= 1'b1;
                        halted_q  <= 1'b1;
                        en_seen_q <= 1'b0;
                        state_q   <= StHalt;
                    end else
`endif
                    if (is_mem) begin
                        d_req_q   <= 1'b1;
                        d_we_q    <= (op == 4'b0100);
                        d_addr_q  <= rs_val + imm_dw;
                        d_wdata_q <= (op == 4'b0100) ? rt_val : '0;
                        state_q   <= StMem;
                    end else begin
                        if (wr_en && wr_idx != 3'd0) regs_q[wr_idx] <= wr_val;
                        pc_q     <= br_taken ? br_tgt : pc_inc;
                        retire_q <= 1'b1;
                        if (is_halt) begin
                            halted_q  <= 1'b1;
                            en_seen_q <= 1'b0;
                            state_q   <= StHalt;
                        end else begin
                            // Pre-raise the next fetch so back-to-back instructions take 2 cycles
                            i_req_q <= ~EN_L;
                            state_q <= StFetch;
                        end
                    end
                end
                StMem: begin
                    if (bus.D_ACK) begin
                        d_req_q <= 1'b0;
                        if (!d_we_q && rt != 3'd0) regs_q[rt] <= bus.D_RDATA;
                        pc_q     <= pc_inc;
                        retire_q <= 1'b1;
                        i_req_q  <= ~EN_L;
                        state_q  <= StFetch;
                    end
                end
                StHalt: begin
                    // Resume only on a fresh high-then-low of EN_L, never on a held low
                    if (EN_L) begin
                        en_seen_q <= 1'b1;
                    end else if (en_seen_q) begin
                        en_seen_q <= 1'b0;
                        halted_q  <= 1'b0;
                        i_req_q   <= 1'b1;
                        state_q   <= StFetch;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    assign bus.I_REQ   = i_req_q;
    assign bus.I_ADDR  = pc_q;
    assign bus.D_REQ   = d_req_q;
    assign bus.D_WE    = d_we_q;
    assign bus.D_ADDR  = d_addr_q;
    assign bus.D_WDATA = d_wdata_q;
    assign PC          = pc_q;
    assign HALTED      = halted_q;
    assign RETIRE      = retire_q;
`ifdef ILLEGAL_TRAP_EN
    assign ILLEGAL     = illegal_q;
`endif

endmodule
